// File: rtl/mul_div_unit_pkg.sv
// Shared types for the iterative multiply/divide unit: RV32M operation codes,
// controller states and small operation-decoding helpers.
package mul_div_unit_pkg;

    typedef enum logic [2:0] {
        MulOp    = 3'b000,
        MulhOp   = 3'b001,
        MulhsuOp = 3'b010,
        MulhuOp  = 3'b011,
        DivOp    = 3'b100,
        DivuOp   = 3'b101,
        RemOp    = 3'b110,
        RemuOp   = 3'b111
    } MulDiv_Ops;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        CALC,
        FIX,
        DONE
    } MulDivState;

    // funct3 bit 2 separates the divide family from the multiply family
    function automatic logic op_is_div(input MulDiv_Ops op);
        return op[2];
    endfunction

    function automatic logic op_is_rem(input MulDiv_Ops op);
        return op[2] & op[1];
    endfunction

    function automatic logic a_is_signed(input MulDiv_Ops op);
        return (op == MulOp) || (op == MulhOp) || (op == MulhsuOp) ||
               (op == DivOp) || (op == RemOp);
    endfunction

    function automatic logic b_is_signed(input MulDiv_Ops op);
        return (op == MulOp) || (op == MulhOp) || (op == DivOp) || (op == RemOp);
    endfunction

endpackage

// File: rtl/mul_div_unit_muldiv_step.sv
// One radix-2 iteration shared by multiply (shift-add, LSB first) and
// divide (restoring shift-subtract); accumulator is {high half, low half}.
module muldiv_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                      is_div,
    input  logic [2*DATA_WIDTH-1:0]   acc_cur,
    input  logic [DATA_WIDTH-1:0]     operand,
    output logic [2*DATA_WIDTH-1:0]   acc_next
);

    logic [DATA_WIDTH-1:0]   hi_half;
    logic [DATA_WIDTH-1:0]   lo_half;
    logic [DATA_WIDTH:0]     sum;
    logic [DATA_WIDTH:0]     rem_shift;
    logic [DATA_WIDTH:0]     diff;
    logic [2*DATA_WIDTH-1:0] mul_next;
    logic [2*DATA_WIDTH-1:0] div_next;

    // Remainder stays below the divisor, so diff's top bit is a clean borrow flag
    always_comb begin
        hi_half   = acc_cur[2*DATA_WIDTH-1:DATA_WIDTH];
        lo_half   = acc_cur[DATA_WIDTH-1:0];
        sum       = {1'b0, hi_half} + (lo_half[0] ? {1'b0, operand} : {(DATA_WIDTH+1){1'b0}});
        mul_next  = {sum, lo_half[DATA_WIDTH-1:1]};
        rem_shift = {hi_half, lo_half[DATA_WIDTH-1]};
        diff      = rem_shift - {1'b0, operand};
        if (diff[DATA_WIDTH]) begin
            div_next = {rem_shift[DATA_WIDTH-1:0], lo_half[DATA_WIDTH-2:0], 1'b0};
        end else begin
            div_next = {diff[DATA_WIDTH-1:0], lo_half[DATA_WIDTH-2:0], 1'b1};
        end
        acc_next = is_div ? div_next : mul_next;
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage: start/ready
// handshake, one bit per cycle, signed results fixed up after the magnitude loop.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  MulDiv_Ops             op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic                  ready_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o
);

    localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    MulDivState              state;
    MulDiv_Ops               op_q;
    logic [DATA_WIDTH-1:0]   a_q;
    logic [DATA_WIDTH-1:0]   b_q;
    logic                    neg_q;
    logic [DATA_WIDTH-1:0]   step_operand;
    logic [2*DATA_WIDTH-1:0] acc;
    logic [2*DATA_WIDTH-1:0] acc_next;
    logic [CNT_WIDTH-1:0]    counter;

    logic                    a_neg;
    logic                    b_neg;
    logic [DATA_WIDTH-1:0]   a_mag;
    logic [DATA_WIDTH-1:0]   b_mag;
    logic                    div_by_zero;
    logic                    overflow;
    logic [DATA_WIDTH-1:0]   special_result;
    logic [2*DATA_WIDTH-1:0] prod_fix;
    logic [DATA_WIDTH-1:0]   quo_fix;
    logic [DATA_WIDTH-1:0]   rem_fix;
    logic [DATA_WIDTH-1:0]   fix_result;

    muldiv_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_step (
        .is_div   (op_is_div(op_q)),
        .acc_cur  (acc),
        .operand  (step_operand),
        .acc_next (acc_next)
    );

    // Operand decode and result fix-up, all from the registered request
    always_comb begin
        a_neg       = a_is_signed(op_q) & a_q[DATA_WIDTH-1];
        b_neg       = b_is_signed(op_q) & b_q[DATA_WIDTH-1];
        a_mag       = a_neg ? -a_q : a_q;
        b_mag       = b_neg ? -b_q : b_q;
        div_by_zero = op_is_div(op_q) && (b_q == '0);
        overflow    = ((op_q == DivOp) || (op_q == RemOp)) &&
                      (a_q == MOST_NEG) && (b_q == '1);

        if (div_by_zero) begin
            special_result = op_is_rem(op_q) ? a_q : '1;
        end else begin
            special_result = op_is_rem(op_q) ? '0 : a_q;
        end

        prod_fix = neg_q ? -acc : acc;
        quo_fix  = neg_q ? -acc[DATA_WIDTH-1:0] : acc[DATA_WIDTH-1:0];
        rem_fix  = neg_q ? -acc[2*DATA_WIDTH-1:DATA_WIDTH] : acc[2*DATA_WIDTH-1:DATA_WIDTH];

        case (op_q)
            MulOp:                       fix_result = prod_fix[DATA_WIDTH-1:0];
            MulhOp, MulhsuOp, MulhuOp:   fix_result = prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
            DivOp, DivuOp:               fix_result = quo_fix;
            default:                     fix_result = rem_fix;
        endcase
    end

    // Controller: requests are captured only in IDLE/DONE, so pokes while busy are dropped
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state        <= IDLE;
            ready_o      <= 1'b1;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            result_o     <= '0;
            counter      <= '0;
            acc          <= '0;
            step_operand <= '0;
            neg_q        <= 1'b0;
            op_q         <= MulOp;
            a_q          <= '0;
            b_q          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        op_q    <= op_i;
                        a_q     <= a_i;
                        b_q     <= b_i;
                        state   <= PREP;
                        ready_o <= 1'b0;
                        busy_o  <= 1'b1;
                    end
                end
                PREP: begin
                    neg_q <= op_is_rem(op_q) ? a_neg : (a_neg ^ b_neg);
                    if (div_by_zero || overflow) begin
                        result_o <= special_result;
                        state    <= DONE;
                        ready_o  <= 1'b1;
                        busy_o   <= 1'b0;
                        done_o   <= 1'b1;
                    end else begin
                        // Divide shifts the dividend out of the low half; multiply shifts the multiplier out
                        acc          <= {{DATA_WIDTH{1'b0}}, (op_is_div(op_q) ? a_mag : b_mag)};
                        step_operand <= op_is_div(op_q) ? b_mag : a_mag;
                        counter      <= CNT_WIDTH'(DATA_WIDTH - 1);
                        state        <= CALC;
                    end
                end
                CALC: begin
                    acc     <= acc_next;
                    counter <= counter - CNT_WIDTH'(1);
                    if (counter == '0) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    result_o <= fix_result;
                    state    <= DONE;
                    ready_o  <= 1'b1;
                    busy_o   <= 1'b0;
                    done_o   <= 1'b1;
                end
                DONE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        op_q    <= op_i;
                        a_q     <= a_i;
                        b_q     <= b_i;
                        state   <= PREP;
                        ready_o <= 1'b0;
                        busy_o  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_o <= 1'b1;
                    busy_o  <= 1'b0;
                    done_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed RV32M cases, handshake and
// reset scenarios, then random operations against a 64-bit arithmetic model.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    localparam int W = 32;
    localparam int NORMAL_LAT = W + 2;

    logic          clk_i;
    logic          reset_i;
    logic          start_i;
    MulDiv_Ops     op_i;
    logic [W-1:0]  a_i;
    logic [W-1:0]  b_i;
    logic          ready_o;
    logic          busy_o;
    logic          done_o;
    logic [W-1:0]  result_o;

    int n_checks = 0;
    int n_errors = 0;

    mul_div_unit #(
        .DATA_WIDTH (W)
    ) dut (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .start_i  (start_i),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .ready_o  (ready_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference model: plain 64-bit arithmetic with RISC-V divide special cases
    function automatic logic [W-1:0] refModel(input MulDiv_Ops op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'b0, a});
        longint ub = longint'({32'b0, b});
        logic [63:0] p;
        case (op)
            MulOp:    begin p = ua * ub; return p[31:0];  end
            MulhOp:   begin p = sa * sb; return p[63:32]; end
            MulhsuOp: begin p = sa * ub; return p[63:32]; end
            MulhuOp:  begin p = ua * ub; return p[63:32]; end
            DivOp: begin
                if (b == 0) return '1;
                if (a == 32'h8000_0000 && b == '1) return a;
                return 32'(sa / sb);
            end
            DivuOp: begin
                if (b == 0) return '1;
                return 32'(ua / ub);
            end
            RemOp: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == '1) return '0;
                return 32'(sa % sb);
            end
            default: begin
                if (b == 0) return a;
                return 32'(ua % ub);
            end
        endcase
    endfunction

    function automatic int refLatency(input MulDiv_Ops op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic is_div;
        logic ovf;
        is_div = (op == DivOp) || (op == DivuOp) || (op == RemOp) || (op == RemuOp);
        ovf    = ((op == DivOp) || (op == RemOp)) && (a == 32'h8000_0000) && (b == '1);
        return (is_div && ((b == 0) || ovf)) ? 1 : NORMAL_LAT;
    endfunction

    function automatic logic [W-1:0] pickOperand();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    // Issues a request from the current time (unit must be in IDLE or DONE);
    // scrambles the inputs while busy and optionally pokes start_i after edge pokeEdge.
    task automatic applyStimulus(input MulDiv_Ops op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input int pokeEdge, output logic [W-1:0] res, output int lat,
                                 output logic busyMid, output logic readyMid);
        op_i    = op;
        a_i     = a;
        b_i     = b;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i  = 1'b0;
        op_i     = MulDiv_Ops'($urandom_range(0, 7));
        a_i      = 32'($urandom);
        b_i      = 32'($urandom);
        lat      = -1;
        busyMid  = 1'b0;
        readyMid = 1'b1;
        for (int e = 1; e <= 100; e++) begin
            @(posedge clk_i);
            #1;
            if (e == 2) begin
                busyMid  = busy_o;
                readyMid = ready_o;
            end
            if (done_o) begin
                lat = e;
                break;
            end
            start_i = (e == pokeEdge);
            if (start_i) begin
                op_i = DivuOp;
                a_i  = 32'd100;
                b_i  = 32'd7;
            end
        end
        start_i = 1'b0;
        if (lat < 0) begin
            checkOutput("done_timeout", 64'(lat), 64'(refLatency(op, a, b)));
        end
        res = result_o;
    endtask

    typedef struct {
        MulDiv_Ops   op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expected;
        int          lat;
        string       tag;
    } Vec;

    Vec directed[$];

    initial begin
        logic [W-1:0] res;
        int           lat;
        logic         busyMid;
        logic         readyMid;
        logic         seenDone;

        reset_i = 1'b1;
        start_i = 1'b0;
        op_i    = MulOp;
        a_i     = '0;
        b_i     = '0;
        repeat (2) @(posedge clk_i);
        #1;
        checkOutput("reset_ready",  64'(ready_o),  64'd1);
        checkOutput("reset_busy",   64'(busy_o),   64'd0);
        checkOutput("reset_done",   64'(done_o),   64'd0);
        checkOutput("reset_result", 64'(result_o), 64'd0);
        reset_i = 1'b0;
        @(negedge clk_i);

        // MUL with done pulse width, mid-operation status and result hold
        applyStimulus(MulOp, 32'd7, 32'hFFFF_FFFD, 0, res, lat, busyMid, readyMid);
        checkOutput("mul_result",  64'(res), 64'hFFFF_FFEB);
        checkOutput("mul_latency", 64'(lat), 64'(NORMAL_LAT));
        checkOutput("mul_busy_mid",  64'(busyMid),  64'd1);
        checkOutput("mul_ready_mid", 64'(readyMid), 64'd0);
        @(posedge clk_i);
        #1;
        checkOutput("mul_done_pulse", 64'(done_o),  64'd0);
        checkOutput("idle_ready",     64'(ready_o), 64'd1);
        checkOutput("idle_busy",      64'(busy_o),  64'd0);
        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("result_hold", 64'(result_o), 64'hFFFF_FFEB);

        directed.push_back('{MulhuOp,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, NORMAL_LAT, "mulhu"});
        directed.push_back('{MulhsuOp, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, NORMAL_LAT, "mulhsu"});
        directed.push_back('{MulhOp,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, NORMAL_LAT, "mulh"});
        directed.push_back('{DivOp,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, NORMAL_LAT, "div"});
        directed.push_back('{RemOp,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, NORMAL_LAT, "rem"});
        directed.push_back('{DivuOp,   32'd100,       32'd7,         32'd14,        NORMAL_LAT, "divu"});
        directed.push_back('{RemuOp,   32'd100,       32'd7,         32'd2,         NORMAL_LAT, "remu"});
        directed.push_back('{DivuOp,   32'd5,         32'd0,         32'hFFFF_FFFF, 1,          "divu_by0"});
        directed.push_back('{RemuOp,   32'd5,         32'd0,         32'd5,         1,          "remu_by0"});
        directed.push_back('{DivOp,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,          "div_ovf"});
        directed.push_back('{RemOp,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1,          "rem_ovf"});

        foreach (directed[i]) begin
            @(negedge clk_i);
            applyStimulus(directed[i].op, directed[i].a, directed[i].b, 0, res, lat, busyMid, readyMid);
            checkOutput({directed[i].tag, "_result"},  64'(res), 64'(directed[i].expected));
            checkOutput({directed[i].tag, "_latency"}, 64'(lat), 64'(directed[i].lat));
        end

        // start_i poked during CALC must be ignored
        @(negedge clk_i);
        applyStimulus(MulOp, 32'd7, 32'hFFFF_FFFD, 5, res, lat, busyMid, readyMid);
        checkOutput("poke_result",  64'(res), 64'hFFFF_FFEB);
        checkOutput("poke_latency", 64'(lat), 64'(NORMAL_LAT));

        // Back-to-back: second request issued in the DONE cycle
        applyStimulus(DivuOp, 32'd100, 32'd7, 0, res, lat, busyMid, readyMid);
        checkOutput("b2b_divu_result",  64'(res), 64'd14);
        checkOutput("b2b_divu_latency", 64'(lat), 64'(NORMAL_LAT));

        // Reset sampled at edge 10 of a MUL aborts it
        @(negedge clk_i);
        op_i    = MulOp;
        a_i     = 32'd123;
        b_i     = 32'd456;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        repeat (9) @(posedge clk_i);
        #1;
        reset_i = 1'b1;
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        checkOutput("abort_ready",  64'(ready_o),  64'd1);
        checkOutput("abort_busy",   64'(busy_o),   64'd0);
        checkOutput("abort_result", 64'(result_o), 64'd0);
        seenDone = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (done_o) seenDone = 1'b1;
            @(posedge clk_i);
            #1;
        end
        checkOutput("abort_no_done", 64'(seenDone), 64'd0);
        @(negedge clk_i);
        applyStimulus(MulOp, 32'd3, 32'd4, 0, res, lat, busyMid, readyMid);
        checkOutput("post_reset_mul", 64'(res), 64'd12);

        // Random operations, some issued back-to-back from DONE
        for (int i = 0; i < 200; i++) begin
            MulDiv_Ops    rop;
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            int           gap;
            rop = MulDiv_Ops'($urandom_range(0, 7));
            ra  = pickOperand();
            rb  = pickOperand();
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk_i);
            applyStimulus(rop, ra, rb, 0, res, lat, busyMid, readyMid);
            checkOutput($sformatf("rnd%0d_%s_result", i, rop.name()), 64'(res), 64'(refModel(rop, ra, rb)));
            checkOutput($sformatf("rnd%0d_%s_latency", i, rop.name()), 64'(lat), 64'(refLatency(rop, ra, rb)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative, parametrised multiply/divide execution unit implementing the RV32M operation set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for a generic DATA_WIDTH.
- Sits beside the combinational ALU in the execute stage.
- The control matrix starts it with a start/ready handshake and stalls until done_o.
- Radix-2, one bit per cycle; shared hardware for multiply and divide.

Parameters:
- DATA_WIDTH, 32, operand and result width (>= 4).
- CNT_WIDTH, $clog2(DATA_WIDTH), iteration counter width.

Ports:
- clk_i  input  1  clock.
- reset_i  input  1  synchronous, active-high reset.
- start_i  input  1  request; accepted only when ready_o=1.
- op_i  input  MulDiv_Ops (3)  operation; sampled with start_i.
- a_i  input  DATA_WIDTH  rs1 (multiplicand/dividend); sampled with start_i.
- b_i  input  DATA_WIDTH  rs2 (multiplier/divisor); sampled with start_i.
- ready_o  output  1  unit can accept start_i.
- busy_o  output  1  operation in progress.
- done_o  output  1  one-cycle pulse; result_o valid.
- result_o  output  DATA_WIDTH  result; held until the next accepted start.

Interface: one clock; reset is synchronous and active-high.

Behaviour:
- Reset: state=IDLE, ready_o=1, busy_o=0, done_o=0, result_o=0, counter=0, internal accumulators=0.
- Reset mid-operation aborts immediately, with no done_o and result_o=0.
- States and transitions:
  - IDLE: start_i -> PREP.
  - PREP: take magnitudes and record result sign, then check special cases. Special case -> DONE; otherwise -> CALC with counter=DATA_WIDTH-1.
  - CALC: one iteration per cycle; counter==0 -> FIX.
  - FIX: apply sign correction and select the result half -> DONE.
  - DONE: done_o=1 for exactly this cycle; start_i -> PREP (back-to-back), else -> IDLE.
- ready_o=1 in IDLE and DONE; busy_o=1 in PREP, CALC and FIX.
- start_i while busy_o=1 is ignored, with no state or operand change.
- Latency, counted from the edge that samples start_i as edge 0:
  - normal ops: done_o high after edge DATA_WIDTH+2;
  - special cases: done_o high after edge 1.
- Signedness of operands:
  - MUL, MULH, DIV, REM: both signed.
  - MULHSU: a signed, b unsigned.
  - MULHU, DIVU, REMU: both unsigned.
- Multiply:
  - unsigned shift-add of magnitudes into a 2*DATA_WIDTH product;
  - FIX negates the product (two's complement, 2W bits) if the result sign is negative;
  - MUL returns the low half; MULH/MULHSU/MULHU return the high half.
- Divide:
  - restoring shift-subtract on magnitudes;
  - quotient sign = sa^sb; remainder sign = sign of dividend.
- Special cases (RISC-V semantics, no traps):
  - divide by zero: DIV/DIVU -> all ones; REM/REMU -> a_i.
  - signed overflow (a_i = most negative value, b_i = all ones): DIV -> a_i; REM -> 0.
- Operands are registered at accept, so changes on a_i/b_i/op_i during busy have no effect.
- No flags output; branch flags remain the ALU's job.

Decomposition:
- Shared package (alongside ALU_Ops):
  - MulDiv_Ops enum using RV funct3 encoding: MulOp=000, MulhOp=001, MulhsuOp=010, MulhuOp=011, DivOp=100, DivuOp=101, RemOp=110, RemuOp=111;
  - MulDivState enum {IDLE, PREP, CALC, FIX, DONE}.
- One natural sub-module, muldiv_step: combinational single-iteration datapath (add-or-pass for multiply, subtract-and-restore for divide) that takes the current accumulator/remainder and returns the next. The FSM and counter stay in mul_div_unit.

Test Plan (DATA_WIDTH=32):
- MUL: a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB; done_o high after edge 34, for exactly one cycle.
- MULHU: a=b=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU: a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF. MULH: a=b=0x80000000 -> 0x40000000.
- DIV and REM: a=0xFFFFFFF9 (-7), b=2 -> DIV 0xFFFFFFFD, REM 0xFFFFFFFF. DIVU: a=100, b=7 -> 14. REMU: same operands -> 2.
- Divide by zero: DIVU 5/0 -> 0xFFFFFFFF, done_o after edge 1; REMU 5/0 -> 5. Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
- Handshake:
  - start_i pulsed with different operands during CALC -> ignored, original result returned;
  - start_i asserted in the DONE cycle -> accepted, next done_o after DATA_WIDTH+2 further edges;
  - result_o holds between operations.
- Reset mid-CALC: reset_i high for 1 cycle at edge 10 -> next cycle ready_o=1, busy_o=0, result_o=0, no done_o; a subsequent MUL 3*4 -> 12.
